// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX state encodings, parity selectors and line levels
package uart_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-side handshake plus serial line of the UART transmitter
//   P_DATA/Data_valid/PAR_EN/PAR_TYP driven by master, TX_OUT/Busy driven by slave (transmitter)
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;
    modport master (output P_DATA, Data_valid, PAR_EN, PAR_TYP, input TX_OUT, Busy);
    modport slave  (input P_DATA, Data_valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: load/shift register with data bit counter
//   clk, rst     : clock, async active-high reset
//   i_load/i_data: capture a new word and zero the counter
//   i_shift      : shift right, exposing the next bit on o_ser_data
//   i_count/i_clr: advance / clear the bit counter
//   o_ser_data   : current LSB of the shift register
//   o_ser_done   : counter is on the last data bit
module uart_tx_serializer #(parameter int DATA_WIDTH = 8) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_count,
    input  logic                  i_clr,
    output logic                  o_ser_data,
    output logic                  o_ser_done
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= i_load ? i_data : i_shift ? r_shift >> 1 : r_shift;
            r_cnt   <= (i_load || i_clr) ? '0 : i_count ? r_cnt + 1'b1 : r_cnt;
        end
    end
    assign o_ser_data = r_shift[0];
    assign o_ser_done = r_cnt == CW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_top.sv
// uart_tx_top: UART transmitter, start + LSB-first data + optional parity + stop
//   CLK : TX bit clock, one serial bit per cycle
//   RST : async active-high reset
//   bus : uart_tx_if.slave (P_DATA, Data_valid, PAR_EN, PAR_TYP in; TX_OUT, Busy out)
module uart_tx_top #(parameter int DATA_WIDTH = 8) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);
    import uart_pkg::*;
    logic [2:0] r_state, w_next;
    logic       r_tx, w_tx, r_busy, w_busy;
    logic       r_par, r_par_en;
    logic       w_ser_data, w_ser_done;
    logic       w_accept, w_shift, w_count, w_clr;
    assign w_accept = (r_state == S_IDLE) && bus.Data_valid;
    // START emits bit 0 while exposing bit 1; DATA keeps shifting until its last bit
    assign w_shift  = (r_state == S_START) || (r_state == S_DATA && !w_ser_done);
    assign w_count  = (r_state == S_DATA) && !w_ser_done;
    assign w_clr    = (r_state == S_DATA) && w_ser_done;
    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_accept),
        .i_data     (bus.P_DATA),
        .i_shift    (w_shift),
        .i_count    (w_count),
        .i_clr      (w_clr),
        .o_ser_data (w_ser_data),
        .o_ser_done (w_ser_done)
    );
    // next-state decode feeds the output flops so TX_OUT/Busy never glitch
    always_comb begin
        w_next = S_IDLE;
        w_tx   = STOP_BIT;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = w_accept ? S_START : S_IDLE;
                w_tx   = w_accept ? START_BIT : STOP_BIT;
                w_busy = w_accept;
            end
            S_START: begin
                w_next = S_DATA;
                w_tx   = w_ser_data;
                w_busy = 1'b1;
            end
            S_DATA: begin
                w_next = !w_ser_done ? S_DATA : r_par_en ? S_PARITY : S_STOP;
                w_tx   = !w_ser_done ? w_ser_data : r_par_en ? r_par : STOP_BIT;
                w_busy = 1'b1;
            end
            S_PARITY: begin
                w_next = S_STOP;
                w_tx   = STOP_BIT;
                w_busy = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
                w_tx   = STOP_BIT;
                w_busy = 1'b0;
            end
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_tx     <= STOP_BIT;
            r_busy   <= 1'b0;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            if (w_accept) begin
                r_par    <= (bus.PAR_TYP == PAR_ODD) ? ~^bus.P_DATA : ^bus.P_DATA;
                r_par_en <= bus.PAR_EN;
            end
        end
    end
    assign bus.TX_OUT = r_tx;
    assign bus.Busy   = r_busy;
endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: directed self-checking bench for uart_tx_top
module tb_uart_tx_top;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [10:0] line;
    logic [7:0]  rx_d;
    logic        rx_perr, rx_serr;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_top #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9 && pe) return pt ? ~^d : ^d;
        return 1'b1;
    endfunction

    // called right after the accepting edge; returns on the stop-bit negedge
    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                               output logic [10:0] obs);
        int len = pe ? 11 : 10;
        obs = '1;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            obs[j] = bus.TX_OUT;
            check({tag, "_bit"}, 32'(bus.TX_OUT), 32'(exp_bit(d, pe, pt, j)));
            check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, 32'(bus.TX_OUT), 32'd1);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                        output logic [10:0] obs);
        @(negedge clk);
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.Data_valid = 1'b1;
        @(posedge clk);
        fork
            check_frame(tag, d, pe, pt, obs);
            begin @(negedge clk); bus.Data_valid = 1'b0; end
        join
        @(negedge clk);
        check_idle({tag, "_end"});
    endtask

    // bench-side receiver: waits (bounded) for the start bit, then samples the frame
    task automatic rx_frame(input logic pe, input logic pt, output logic [7:0] d,
                            output logic perr, output logic serr);
        int t = 0;
        d = '0;
        perr = 1'b0;
        @(negedge clk);
        while (bus.TX_OUT !== 1'b0 && t < 5) begin
            @(negedge clk);
            t++;
        end
        check("rx_start", 32'(bus.TX_OUT), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d[i] = bus.TX_OUT;
        end
        if (pe) begin
            @(negedge clk);
            perr = bus.TX_OUT != (pt ? ~^d : ^d);
        end
        @(negedge clk);
        serr = bus.TX_OUT != 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.P_DATA = '0;
        bus.Data_valid = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset asserted in the middle of a frame
        bus.P_DATA = 8'h00;
        bus.Data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_tx", 32'(bus.TX_OUT), 32'd0);
        check("mid_busy", 32'(bus.Busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check_idle("idle20");
        end

        // plain frame, no parity
        send("a5", 8'hA5, 1'b0, 1'b0, line);
        check("a5_line", 32'(line[9:0]), 32'(10'b1101001010));

        // parity frames
        send("p03", 8'h03, 1'b1, 1'b0, line);
        check("p03_line", 32'(line), 32'(11'b10000000110));
        send("p07", 8'h07, 1'b1, 1'b1, line);
        check("p07_line", 32'(line), 32'(11'b10000001110));

        // Data_valid held high: back-to-back frames with one idle cycle
        @(negedge clk);
        bus.P_DATA = 8'h55;
        bus.PAR_EN = 1'b0;
        bus.Data_valid = 1'b1;
        @(posedge clk);
        fork
            check_frame("b55", 8'h55, 1'b0, 1'b0, line);
            begin @(negedge clk); bus.P_DATA = 8'hAA; end
        join
        @(negedge clk);
        check_idle("gap");
        @(posedge clk);
        fork
            check_frame("baa", 8'hAA, 1'b0, 1'b0, line);
            begin @(negedge clk); bus.Data_valid = 1'b0; end
        join
        @(negedge clk);
        check_idle("baa_end");

        // strobe during STOP is dropped
        @(negedge clk);
        bus.P_DATA = 8'h3C;
        bus.Data_valid = 1'b1;
        @(posedge clk);
        fork
            check_frame("s3c", 8'h3C, 1'b0, 1'b0, line);
            begin
                @(negedge clk);
                bus.Data_valid = 1'b0;
                repeat (9) @(negedge clk);
                bus.Data_valid = 1'b1;
                @(negedge clk);
                bus.Data_valid = 1'b0;
            end
        join
        check_idle("stop_drop");
        repeat (12) begin
            @(negedge clk);
            check_idle("no_extra");
        end

        // inputs changed mid-frame do not disturb it
        @(negedge clk);
        bus.P_DATA = 8'hC6;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        bus.Data_valid = 1'b1;
        @(posedge clk);
        fork
            check_frame("chg", 8'hC6, 1'b1, 1'b1, line);
            begin
                @(negedge clk);
                bus.Data_valid = 1'b0;
                @(negedge clk);
                bus.P_DATA = 8'h39;
                bus.PAR_EN = 1'b0;
                bus.PAR_TYP = 1'b0;
            end
        join
        @(negedge clk);
        check_idle("chg_end");

        // loopback into a bench receiver, all parity modes
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d = 8'($urandom);
            logic pe = i[1];
            logic pt = i[0];
            @(negedge clk);
            bus.P_DATA = d;
            bus.PAR_EN = pe;
            bus.PAR_TYP = pt;
            bus.Data_valid = 1'b1;
            fork
                rx_frame(pe, pt, rx_d, rx_perr, rx_serr);
                begin @(negedge clk); bus.Data_valid = 1'b0; end
            join
            check("lb_data", 32'(rx_d), 32'(d));
            check("lb_par_err", 32'(rx_perr), 32'd0);
            check("lb_stp_err", 32'(rx_serr), 32'd0);
        end
        @(negedge clk);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
